// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage: forwarding select codes,
// the ID-side control bundle and the ALU opcode width.
package pipe_pkg;

  localparam int unsigned ALUW = 4;

  // Bypass-unit select codes; 2'b11 is reserved and behaves as FWD_REGFILE.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

  typedef struct packed {
    logic [ALUW-1:0] alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_NONE = '0;

  // Folds the reserved code onto the regfile path so muxes only see three cases.
  function automatic logic [1:0] fwd_norm(input logic [1:0] sel);
    return (sel == 2'b11) ? FWD_REGFILE : sel;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX will write. Purely combinational.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rd,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          lu
);

  logic rd_nonzero;
  logic src_match;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  always_comb begin
    rd_nonzero = (ex_rd != '0);
    src_match  = (ex_rd == id_rs) || (ex_rd == id_rt);
    lu         = ex_valid && ex_mem_read && rd_nonzero && id_valid && src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core. Applies the bypass
// selections to the operands, registers operands/control/indices into EX and
// inserts a bubble on a load-use hazard (with a one-cycle stall) or on a
// branch flush from EX.
// Optional build macro ID_EX_PERF_CNT_EN adds perf_stall_cnt/perf_flush_cnt.
// ALU opcode width comes from pipe_pkg::ALUW.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [DW-1:0]   id_rs_data,
  input  logic [DW-1:0]   id_rt_data,
  input  logic [DW-1:0]   id_imm,
  input  logic [ALUW-1:0] id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [DW-1:0]   exmem_result,
  input  logic [DW-1:0]   memwb_wdata,
  input  logic            ex_flush,
  output logic            stall_o,
  output logic            ex_valid,
  output logic [DW-1:0]   ex_a,
  output logic [DW-1:0]   ex_b,
  output logic [DW-1:0]   ex_store_data,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic [ALUW-1:0] ex_alu_op,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  logic        lu;
  logic        bubble;
  id_ex_ctrl_t id_ctrl;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  logic            valid_d;
  logic [DW-1:0]   a_d;
  logic [DW-1:0]   b_d;
  logic [DW-1:0]   store_data_d;
  logic [RW-1:0]   rs_d;
  logic [RW-1:0]   rt_d;
  logic [RW-1:0]   rd_d;
  logic [ALUW-1:0] alu_op_d;
  logic            reg_write_d;
  logic            mem_read_d;
  logic            mem_write_d;

  load_use_detect #(
    .RW(RW)
  ) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .lu          (lu)
  );

  // A flush squashes the ID instruction, so a simultaneous hazard must not hold it.
  always_comb begin
    stall_o = lu && !ex_flush && !rst;
    bubble  = ex_flush || lu;
  end

  // Gather ID control; an empty ID slot carries no side effects into EX.
  always_comb begin
    id_ctrl = CTRL_NONE;
    if (id_valid) begin
      id_ctrl.alu_op    = id_alu_op;
      id_ctrl.alu_src   = id_alu_src;
      id_ctrl.reg_write = id_reg_write;
      id_ctrl.mem_read  = id_mem_read;
      id_ctrl.mem_write = id_mem_write;
    end
  end

  // Operand bypass muxes ahead of the pipeline register.
  always_comb begin
    op_a = id_rs_data;
    case (fwd_norm(fwd_a))
      FWD_EXMEM: op_a = exmem_result;
      FWD_MEMWB: op_a = memwb_wdata;
      default:   op_a = id_rs_data;
    endcase
    op_b = id_rt_data;
    case (fwd_norm(fwd_b))
      FWD_EXMEM: op_b = exmem_result;
      FWD_MEMWB: op_b = memwb_wdata;
      default:   op_b = id_rt_data;
    endcase
  end

  // Next EX contents: either the ID instruction or an all-zero bubble.
  always_comb begin
    valid_d      = 1'b0;
    a_d          = '0;
    b_d          = '0;
    store_data_d = '0;
    rs_d         = '0;
    rt_d         = '0;
    rd_d         = '0;
    alu_op_d     = '0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    if (!bubble) begin
      valid_d      = id_valid;
      a_d          = op_a;
      b_d          = id_ctrl.alu_src ? id_imm : op_b;
      store_data_d = op_b;
      rs_d         = id_rs;
      rt_d         = id_rt;
      rd_d         = id_rd;
      alu_op_d     = id_ctrl.alu_op;
      reg_write_d  = id_ctrl.reg_write;
      mem_read_d   = id_ctrl.mem_read;
      mem_write_d  = id_ctrl.mem_write;
    end
  end

  // The ID/EX register itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_store_data <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_alu_op     <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
    end else begin
      ex_valid      <= valid_d;
      ex_a          <= a_d;
      ex_b          <= b_d;
      ex_store_data <= store_data_d;
      ex_rs         <= rs_d;
      ex_rt         <= rt_d;
      ex_rd         <= rd_d;
      ex_alu_op     <= alu_op_d;
      ex_reg_write  <= reg_write_d;
      ex_mem_read   <= mem_read_d;
      ex_mem_write  <= mem_write_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Bubble-cause counters; a flush overlapping a hazard counts only as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (ex_flush) begin
      perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end else if (lu) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: operand-mux vector table, hand-written
// hazard/flush/reset sequences and a randomized run against a behavioural model.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [RW-1:0]   id_rs, id_rt, id_rd;
  logic [DW-1:0]   id_rs_data, id_rt_data, id_imm;
  logic [ALUW-1:0] id_alu_op;
  logic            id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [1:0]      fwd_a, fwd_b;
  logic [DW-1:0]   exmem_result, memwb_wdata;
  logic            ex_flush;
  logic            stall_o, ex_valid;
  logic [DW-1:0]   ex_a, ex_b, ex_store_data;
  logic [RW-1:0]   ex_rs, ex_rt, ex_rd;
  logic [ALUW-1:0] ex_alu_op;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_result(exmem_result),
    .memwb_wdata(memwb_wdata), .ex_flush(ex_flush), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
`ifdef ID_EX_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Behavioural picture of what EX should hold.
  logic        m_valid, m_rw, m_mr, m_mw, m_data_known;
  logic [31:0] m_rs, m_rt, m_rd, m_a, m_b, m_sd, m_op;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b10) return exmem_result;
    if (sel == 2'b01) return memwb_wdata;
    return rf;
  endfunction

  function automatic logic model_hazard();
    return m_valid && m_mr && (m_rd != 0) && id_valid &&
           ((m_rd == 32'(id_rs)) || (m_rd == 32'(id_rt)));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(m_rw));
    chk({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(m_mr));
    chk({tag, ".ex_mem_write"}, 32'(ex_mem_write), 32'(m_mw));
    chk({tag, ".ex_rs"}, 32'(ex_rs), m_rs);
    chk({tag, ".ex_rt"}, 32'(ex_rt), m_rt);
    chk({tag, ".ex_rd"}, 32'(ex_rd), m_rd);
    if (m_data_known) begin
      chk({tag, ".ex_a"}, ex_a, m_a);
      chk({tag, ".ex_b"}, ex_b, m_b);
      chk({tag, ".ex_store_data"}, ex_store_data, m_sd);
      chk({tag, ".ex_alu_op"}, 32'(ex_alu_op), m_op);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".perf_stall_cnt"}, perf_stall_cnt, m_stall_cnt);
    chk({tag, ".perf_flush_cnt"}, perf_flush_cnt, m_flush_cnt);
`endif
  endtask

  // Check the combinational stall, advance model and DUT one edge, check EX.
  task automatic cycle(input string tag);
    logic lu;
    #1;
    lu = model_hazard();
    chk({tag, ".stall_o"}, 32'(stall_o), 32'(lu && !ex_flush && !rst));
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw} = '0;
      {m_rs, m_rt, m_rd, m_a, m_b, m_sd, m_op} = '0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_data_known = 1'b1;
    end else if (ex_flush || lu) begin
      {m_valid, m_rw, m_mr, m_mw} = '0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_data_known = 1'b0;
      if (ex_flush) m_flush_cnt = m_flush_cnt + 1;
      else          m_stall_cnt = m_stall_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_rw = id_valid && id_reg_write;
      m_mr = id_valid && id_mem_read;
      m_mw = id_valid && id_mem_write;
      m_op = id_valid ? 32'(id_alu_op) : 0;
      m_rs = 32'(id_rs); m_rt = 32'(id_rt); m_rd = 32'(id_rd);
      m_a  = pick(fwd_a, id_rs_data);
      m_sd = pick(fwd_b, id_rt_data);
      m_b  = (id_valid && id_alu_src) ? id_imm : m_sd;
      m_data_known = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_op = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    fwd_a = 0; fwd_b = 0; exmem_result = 0; memwb_wdata = 0; ex_flush = 0;
  endtask

  task automatic instr(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input logic load);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
    id_mem_read = load; id_reg_write = 1; id_mem_write = 0; id_alu_op = 4'h2;
    id_alu_src = load; fwd_a = 0; fwd_b = 0;
  endtask

  typedef struct {
    logic [1:0]  fa, fb;
    logic        src;
    logic [31:0] rs_data, rt_data, imm, exmem, memwb;
    logic [31:0] ea, eb, esd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'b10, 2'b00, 1'b0, 32'h5, 32'h9, 32'h0, 32'h1234, 32'h0,
                32'h1234, 32'h9, 32'h9};
    vecs[1] = '{2'b01, 2'b01, 1'b0, 32'h5, 32'h9, 32'h0, 32'h1234, 32'h77,
                32'h77, 32'h77, 32'h77};
    vecs[2] = '{2'b11, 2'b11, 1'b0, 32'hA5A5, 32'h5A5A, 32'h0, 32'h1, 32'h2,
                32'hA5A5, 32'h5A5A, 32'h5A5A};
    vecs[3] = '{2'b00, 2'b10, 1'b1, 32'h3, 32'h4, 32'hFFFF_FFF0, 32'hCAFE, 32'h8,
                32'h3, 32'hFFFF_FFF0, 32'hCAFE};
    vecs[4] = '{2'b10, 2'b10, 1'b0, 32'h3, 32'h4, 32'h10, 32'hDEAD_BEEF, 32'h8,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{2'b00, 2'b00, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55,
                32'h11, 32'h33, 32'h22};

    idle_inputs();
    rst = 1;
    cycle("reset0");
    cycle("reset1");
    rst = 0;
    cycle("post_reset");

    // Operand mux table.
    for (int i = 0; i < 6; i++) begin
      instr(5'd7, 5'd8, 5'd9, 1'b0);
      fwd_a = vecs[i].fa; fwd_b = vecs[i].fb; id_alu_src = vecs[i].src;
      id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data; id_imm = vecs[i].imm;
      exmem_result = vecs[i].exmem; memwb_wdata = vecs[i].memwb;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.a", i), ex_a, vecs[i].ea);
      chk($sformatf("vec%0d.b", i), ex_b, vecs[i].eb);
      chk($sformatf("vec%0d.sd", i), ex_store_data, vecs[i].esd);
    end

    // Load-use: lw $3 then add using $3.
    instr(5'd1, 5'd0, 5'd3, 1'b1);
    cycle("lu_load");
    instr(5'd3, 5'd4, 5'd5, 1'b0);
    #1 chk("lu_stall_hi", 32'(stall_o), 32'd1);
    cycle("lu_bubble");
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
    #1 chk("lu_stall_lo", 32'(stall_o), 32'd0);
    cycle("lu_retry");
    chk("lu_retry_rd", 32'(ex_rd), 32'd5);
    chk("lu_retry_valid", 32'(ex_valid), 32'd1);

    // Load to $0 is never a hazard.
    instr(5'd1, 5'd2, 5'd0, 1'b1);
    cycle("r0_load");
    instr(5'd0, 5'd0, 5'd6, 1'b0);
    #1 chk("r0_no_stall", 32'(stall_o), 32'd0);
    cycle("r0_use");
    chk("r0_no_bubble", 32'(ex_valid), 32'd1);

    // Flush together with a load-use hazard.
    instr(5'd1, 5'd2, 5'd3, 1'b1);
    cycle("fl_load");
    instr(5'd2, 5'd3, 5'd4, 1'b0);
    ex_flush = 1;
    #1 chk("fl_no_stall", 32'(stall_o), 32'd0);
    cycle("fl_bubble");
    chk("fl_bubble_valid", 32'(ex_valid), 32'd0);
    ex_flush = 0;

    // Reset arriving while a stall is pending.
    instr(5'd1, 5'd2, 5'd3, 1'b1);
    cycle("rs_load");
    instr(5'd3, 5'd3, 5'd4, 1'b0);
    rst = 1;
    #1 chk("rs_stall_drop", 32'(stall_o), 32'd0);
    cycle("rs_reset");
    chk("rs_valid", 32'(ex_valid), 32'd0);
    rst = 0;
    idle_inputs();
    cycle("rs_idle");

    // Randomized traffic against the model; small register range for frequent hazards.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      ex_flush     = ($urandom_range(0, 9) == 0);
      id_valid     = ($urandom_range(0, 4) != 0);
      id_rs        = RW'($urandom_range(0, 3));
      id_rt        = RW'($urandom_range(0, 3));
      id_rd        = RW'($urandom_range(0, 3));
      id_rs_data   = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      exmem_result = $urandom; memwb_wdata = $urandom;
      id_alu_op    = ALUW'($urandom);
      id_alu_src   = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read  = 1'($urandom); id_mem_write = 1'($urandom);
      fwd_a        = 2'($urandom); fwd_b = 2'($urandom);
      cycle($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
